pc_fetch_unit: RTL
==================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, reset, synchronous and active-high.
REQ-004 The block SHALL have port redirect_valid, input, 1 bit, a branch/jump redirect request.
REQ-005 The block SHALL have port redirect_pc, input, 32 bits, the redirect target.
REQ-006 The block SHALL have port imem_req_valid, output, 1 bit, instruction-memory request valid.
REQ-007 The block SHALL have port imem_req_addr, output, 32 bits, the request address (current PC).
REQ-008 The block SHALL have port imem_req_ready, input, 1 bit; a request is accepted when both valid and ready are high.
REQ-009 The block SHALL have port imem_rsp_valid, input, 1 bit; memory responses arrive in order, at most one per cycle, at least 1 cycle after acceptance.
REQ-010 The block SHALL have port imem_rsp_data, input, 32 bits, the instruction word.
REQ-011 The block SHALL have port instr_valid, output, 1 bit, an instruction available to decode.
REQ-012 The block SHALL have port instr, output, 32 bits, the instruction word to the decoder.
REQ-013 The block SHALL have port instr_pc, output, 32 bits, the address of instr.
REQ-014 The block SHALL have port instr_ready, input, 1 bit; the decoder consumes an instruction when both valid and ready are high.
REQ-015 The block SHALL have port misalign_err, output, 1 bit, present only under PC_MISALIGN_CHECK_EN.

Function
REQ-016 The state machine SHALL have states START, RUN, DRAIN and HALT, and SHALL go from START to RUN unconditionally after one cycle.
REQ-017 imem_req_valid SHALL be high only in RUN, and only when queue occupancy plus live outstanding requests is less than 2.
REQ-018 On request acceptance, the block SHALL update pc to pc+4, wrapping modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0).
REQ-019 While a request is pending (valid high, ready low), imem_req_addr SHALL be stable except on redirect.
REQ-020 Each live response SHALL be written with its PC into a 2-entry FIFO, and instr/instr_pc SHALL be driven from the FIFO head.
REQ-021 instr_valid SHALL assert when the FIFO is non-empty, giving 1-cycle latency from response to instr_valid.
REQ-022 The block SHALL support enqueue and dequeue in the same cycle, and no response SHALL ever be lost; credit gating (REQ-017) guarantees no overflow.
REQ-023 On redirect_valid, the block SHALL set pc to redirect_pc, flush the FIFO (instr_valid=0 next cycle), and mark all outstanding requests, including one accepted that same cycle, as dropped.
REQ-024 On redirect with a nonzero drop count, the block SHALL enter DRAIN, issue no requests, discard each response while decrementing the count, and return to RUN when the count reaches 0; a response in the redirect cycle itself SHALL be discarded.
REQ-025 A redirect arriving in DRAIN SHALL update pc, and the drop count SHALL remain consistent.
REQ-026 Redirect SHALL take priority over simultaneous enqueue, dequeue and acceptance.

Reset
REQ-027 On rst the block SHALL set pc=RESET_PC, state=START, the FIFO empty, and outstanding/drop counts to 0.
REQ-028 On rst the block SHALL drive imem_req_valid=0, instr_valid=0, instr=0, instr_pc=0 and misalign_err=0.
REQ-029 Reset mid-operation SHALL abandon all in-flight state, and the memory SHALL be reset by the same rst so that no stale responses follow.

Configuration
REQ-030 With PC_MISALIGN_CHECK_EN defined, a redirect_pc with [1:0]!=0 SHALL set misalign_err sticky high and enter HALT; in HALT there are no requests, the FIFO is flushed, and the block leaves HALT only on rst.
REQ-031 Without PC_MISALIGN_CHECK_EN, the misalign_err port SHALL be absent, redirect_pc[1:0] SHALL be forced to 2'b00, and HALT SHALL be unreachable.

Verification
REQ-032 The bench SHALL cover: reset, ready=1, 1-cycle memory, instr_ready=1 -> requests at 0x0,0x4,0x8 on successive cycles, with instr_pc following in order.
REQ-033 The bench SHALL cover: instr_ready=0 for 10 cycles -> at most 2 accepted requests, then valid=0; on instr_ready=1, 0x0 then 0x4 with nothing lost.
REQ-034 The bench SHALL cover: 3-cycle memory latency, redirect to 0x100 with 2 outstanding -> both responses discarded, DRAIN for those cycles, first instr_pc=0x100.
REQ-035 The bench SHALL cover: redirect to 0x200 in the same cycle a request for 0x8 is accepted -> the 0x8 response is dropped and the next request is 0x200.
REQ-036 The bench SHALL cover: RESET_PC=32'hFFFF_FFF8 -> request addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
REQ-037 The bench SHALL cover: with the macro, redirect to 0x102 -> misalign_err=1 next cycle, no further requests until rst; without the macro, the next request is 0x100.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC sequencer, credit-gated imem requests and 2-entry instruction queue
// Optional build macro PC_MISALIGN_CHECK_EN: misaligned redirect sets misalign_err and halts until rst.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
`ifdef PC_MISALIGN_CHECK_EN
  ,
  output logic        misalign_err
`endif
);

  typedef enum logic [1:0] {START, RUN, DRAIN, HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q;

  logic [31:0] fifo_data [2];
  logic [31:0] fifo_pc   [2];
  logic [1:0]  fifo_cnt;

  // PCs of live (not dropped) outstanding requests, oldest at index 0
  logic [31:0] out_pc [2];
  logic [1:0]  live_cnt;
  logic [1:0]  drop_cnt;

  logic [2:0]  occ;
  logic        accept;
  logic        deq;
  logic        flush;
  logic        do_redirect;
  logic        bad_target;
  logic        live_rsp;
  logic        drop_rsp;
  logic [31:0] target;
  logic [1:0]  drop_next;

`ifdef PC_MISALIGN_CHECK_EN
  assign target     = redirect_pc;
  assign bad_target = redirect_valid && (redirect_pc[1:0] != 2'b00) && (state_q != HALT);
`else
  assign target     = redirect_pc & 32'hFFFF_FFFC;
  assign bad_target = 1'b0;
`endif

  assign do_redirect    = redirect_valid && (state_q != HALT) && !bad_target;
  assign flush          = do_redirect || bad_target;

  assign occ            = {1'b0, fifo_cnt} + {1'b0, live_cnt};
  assign imem_req_valid = (state_q == RUN) && (occ < 3'd2);
  assign imem_req_addr  = pc_q;
  assign accept         = imem_req_valid && imem_req_ready;

  assign instr_valid    = (fifo_cnt != 2'd0);
  assign instr          = instr_valid ? fifo_data[0] : 32'h0;
  assign instr_pc       = instr_valid ? fifo_pc[0]   : 32'h0;
  assign deq            = instr_valid && instr_ready && !flush;

  // Dropped requests are always older than live ones: no issue happens until the drop count drains.
  assign live_rsp  = imem_rsp_valid && !flush && (drop_cnt == 2'd0) && (state_q != HALT);
  assign drop_rsp  = imem_rsp_valid && !flush && (drop_cnt != 2'd0);
  assign drop_next = drop_cnt + live_cnt + {1'b0, accept} - {1'b0, imem_rsp_valid};

  always_comb begin
    state_d = state_q;
    if (bad_target) begin
      state_d = HALT;
    end else begin
      case (state_q)
        START: state_d = RUN;
        RUN: begin
          if (do_redirect && (drop_next != 2'd0)) state_d = DRAIN;
        end
        DRAIN: begin
          if (do_redirect) begin
            state_d = (drop_next != 2'd0) ? DRAIN : RUN;
          end else if (drop_rsp && (drop_cnt == 2'd1)) begin
            state_d = RUN;
          end
        end
        HALT:    state_d = HALT;
        default: state_d = START;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= START;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      drop_cnt <= 2'd0;
    end else begin
      if (do_redirect) begin
        pc_q <= target;
      end else if (accept) begin
        pc_q <= pc_q + 32'd4;
      end
      if (bad_target) begin
        drop_cnt <= 2'd0;
      end else if (do_redirect) begin
        drop_cnt <= drop_next;
      end else if (drop_rsp) begin
        drop_cnt <= drop_cnt - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      live_cnt  <= 2'd0;
      out_pc[0] <= 32'h0;
      out_pc[1] <= 32'h0;
    end else if (flush) begin
      live_cnt <= 2'd0;
    end else begin
      case ({accept, live_rsp})
        2'b10: begin
          out_pc[live_cnt[0]] <= pc_q;
          live_cnt            <= live_cnt + 2'd1;
        end
        2'b01: begin
          out_pc[0] <= out_pc[1];
          live_cnt  <= live_cnt - 2'd1;
        end
        2'b11: begin
          if (live_cnt == 2'd1) begin
            out_pc[0] <= pc_q;
          end else begin
            out_pc[0] <= out_pc[1];
            out_pc[1] <= pc_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Head-at-0 queue; credit gating keeps it from ever being written while full.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_cnt     <= 2'd0;
      fifo_data[0] <= 32'h0;
      fifo_data[1] <= 32'h0;
      fifo_pc[0]   <= 32'h0;
      fifo_pc[1]   <= 32'h0;
    end else if (flush) begin
      fifo_cnt <= 2'd0;
    end else begin
      case ({live_rsp, deq})
        2'b10: begin
          fifo_data[fifo_cnt[0]] <= imem_rsp_data;
          fifo_pc[fifo_cnt[0]]   <= out_pc[0];
          fifo_cnt               <= fifo_cnt + 2'd1;
        end
        2'b01: begin
          fifo_data[0] <= fifo_data[1];
          fifo_pc[0]   <= fifo_pc[1];
          fifo_cnt     <= fifo_cnt - 2'd1;
        end
        2'b11: begin
          if (fifo_cnt == 2'd1) begin
            fifo_data[0] <= imem_rsp_data;
            fifo_pc[0]   <= out_pc[0];
          end else begin
            fifo_data[0] <= fifo_data[1];
            fifo_pc[0]   <= fifo_pc[1];
            fifo_data[1] <= imem_rsp_data;
            fifo_pc[1]   <= out_pc[0];
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PC_MISALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_err <= 1'b0;
    end else if (bad_target) begin
      misalign_err <= 1'b1;
    end
  end
`endif

endmodule
